emg_irq_notifier: RTL and testbench

AXI4-Lite peripheral that buffers the EMG sample stream and raises a notification interrupt when a programmable number of samples is waiting. It sits between the acquisition front-end, which supplies samples, and the PS, which reads the AXI4-Lite register map. The register map is four 32-bit registers at offsets 0x0–0xC, exercised by the standard sequential AXI4-Lite write/read bench. Software drains the samples by repeated reads of the DATA register.

---
 rtl/emg_irq_pkg.sv | 38 +++
 rtl/emg_sample_fifo.sv | 77 +++++++
 rtl/emg_irq_notifier.sv | 185 ++++++++++++++++++
 tb/tb_emg_irq_notifier.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emg_irq_pkg.sv
// Shared definitions for the EMG interrupt notifier: register offsets,
// bit positions inside CTRL and STATUS, reset constants and the helper
// that turns the programmed threshold into the one actually compared.
package emg_irq_pkg;

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_THRESH = 2'd1,
        ADDR_STATUS = 2'd2,
        ADDR_DATA   = 2'd3
    } reg_addr_e;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_IRQ_EN_BIT      = 1;
    localparam int CTRL_FLUSH_BIT       = 2;

    localparam int STATUS_OVERFLOW_BIT  = 8;
    localparam int STATUS_PENDING_BIT   = 9;
    localparam int STATUS_UNDERFLOW_BIT = 10;

    localparam logic [5:0]  THRESH_RESET     = 6'd8;
    localparam logic [31:0] EMPTY_READ_VALUE = 32'h0000_0000;

    // A zero threshold would mean "always pending", so it behaves as 1;
    // anything larger than the FIFO could never be reached, so it is
    // clamped to the depth.
    function automatic logic [6:0] eff_thresh(input logic [5:0] thresh,
                                              input logic [6:0] depth);
        if (thresh == 6'd0) begin
            return 7'd1;
        end else if ({1'b0, thresh} > depth) begin
            return depth;
        end else begin
            return {1'b0, thresh};
        end
    endfunction

endpackage

// File: rtl/emg_sample_fifo.sv
// Synchronous sample FIFO.
// Ports:
//   clk_i, rst_i   - clock and asynchronous active-high reset
//   push_i, din_i  - write request and data (ignored when full unless popping)
//   pop_i          - read request (ignored when empty)
//   flush_i        - empties the FIFO; wins over a push in the same cycle
//   dout_o         - current head word
//   level_o        - number of stored words
//   full_o, empty_o
module emg_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [DW-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when it is also being read.
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // Storage needs no reset; only words covered by the pointers are read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/emg_irq_notifier.sv
// AXI4-Lite peripheral buffering EMG samples and raising a level interrupt
// once a programmable number of samples is waiting.
// Ports:
//   s00_axi_aclk / s00_axi_areset - clock, asynchronous active-high reset
//   sample_tdata/tvalid/tready    - sample stream from the front-end
//   s00_axi_*                     - AXI4-Lite slave (CTRL, THRESH, STATUS, DATA)
//   irq                           - STATUS.pending & CTRL.irq_en
module emg_irq_notifier #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_areset,
    input  logic [31:0]                         sample_tdata,
    input  logic                                sample_tvalid,
    output logic                                sample_tready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic                                irq
);

    import emg_irq_pkg::*;

    localparam int         LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [6:0] DEPTH_LIMIT = 7'(FIFO_DEPTH);

    logic        enable_q, irq_en_q;
    logic [5:0]  thresh_q;
    logic        overflow_q, pending_q, underflow_q;
    logic        overflow_d, pending_d, underflow_d;
    logic        bvalid_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_value;

    logic        wr_fire, rd_fire;
    reg_addr_e   wr_sel, rd_sel;
    logic        ctrl_wr, thresh_wr, status_wr;
    logic        flush, pop, push_req;

    logic [31:0]   fifo_dout;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;

    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                             s00_axi_araddr[1:0], s00_axi_wdata, s00_axi_wstrb};

    emg_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (32)
    ) u_fifo (
        .clk_i   (s00_axi_aclk),
        .rst_i   (s00_axi_areset),
        .push_i  (push_req),
        .din_i   (sample_tdata),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshake decode. AW and W are only taken together and only while no
    // write response is waiting, so at most one write is ever outstanding.
    // Flush is a pulse derived straight from the CTRL write, never stored.
    always_comb begin
        wr_fire   = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
        rd_fire   = s00_axi_arvalid & ~rvalid_q;
        wr_sel    = reg_addr_e'(s00_axi_awaddr[3:2]);
        rd_sel    = reg_addr_e'(s00_axi_araddr[3:2]);
        ctrl_wr   = wr_fire & (wr_sel == ADDR_CTRL)   & s00_axi_wstrb[0];
        thresh_wr = wr_fire & (wr_sel == ADDR_THRESH) & s00_axi_wstrb[0];
        status_wr = wr_fire & (wr_sel == ADDR_STATUS) & s00_axi_wstrb[1];
        flush     = ctrl_wr & s00_axi_wdata[CTRL_FLUSH_BIT];
        pop       = rd_fire & (rd_sel == ADDR_DATA);
        push_req  = sample_tvalid & enable_q;
    end

    // Sticky flags: a set in the same cycle beats a W1C clear. A sample is
    // only dropped when full and not being popped; a flush discards it
    // silently instead.
    always_comb begin
        overflow_d  = (overflow_q & ~(status_wr & s00_axi_wdata[STATUS_OVERFLOW_BIT]))
                    | (push_req & fifo_full & ~pop & ~flush);
        pending_d   = (pending_q & ~(status_wr & s00_axi_wdata[STATUS_PENDING_BIT]))
                    | (7'(fifo_level) >= eff_thresh(thresh_q, DEPTH_LIMIT));
        underflow_d = (underflow_q & ~(status_wr & s00_axi_wdata[STATUS_UNDERFLOW_BIT]))
                    | (pop & fifo_empty);
    end

    // Read mux, sampled into rdata on the AR handshake.
    always_comb begin
        rd_value = '0;
        case (rd_sel)
            ADDR_CTRL: begin
                rd_value[CTRL_ENABLE_BIT] = enable_q;
                rd_value[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            ADDR_THRESH: rd_value[5:0] = thresh_q;
            ADDR_STATUS: begin
                rd_value[LW-1:0]             = fifo_level;
                rd_value[STATUS_OVERFLOW_BIT]  = overflow_q;
                rd_value[STATUS_PENDING_BIT]   = pending_q;
                rd_value[STATUS_UNDERFLOW_BIT] = underflow_q;
            end
            ADDR_DATA: rd_value = fifo_empty ? EMPTY_READ_VALUE : fifo_dout;
            default:   rd_value = '0;
        endcase
    end

    // Software-visible registers.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            thresh_q    <= THRESH_RESET;
            overflow_q  <= 1'b0;
            pending_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= s00_axi_wdata[CTRL_ENABLE_BIT];
                irq_en_q <= s00_axi_wdata[CTRL_IRQ_EN_BIT];
            end
            if (thresh_wr) begin
                thresh_q <= s00_axi_wdata[5:0];
            end
            overflow_q  <= overflow_d;
            pending_q   <= pending_d;
            underflow_q <= underflow_d;
        end
    end

    // AXI response channels; each response holds until the master accepts it.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_value;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = wr_fire;
    assign s00_axi_wready  = wr_fire;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = ~rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign sample_tready   = enable_q;
    assign irq             = pending_q & irq_en_q;

endmodule

// File: tb/tb_emg_irq_notifier.sv
// Bench for emg_irq_notifier: directed AXI4-Lite and sample-stream traffic,
// a queue-based reference of the register map and FIFO, and literal
// expectations for the headline scenarios.
module tb_emg_irq_notifier;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sample_tdata = '0;
    logic        sample_tvalid = 1'b0;
    logic        sample_tready;
    logic [3:0]  s00_axi_awaddr = '0;
    logic [2:0]  s00_axi_awprot = '0;
    logic        s00_axi_awvalid = 1'b0;
    logic        s00_axi_awready;
    logic [31:0] s00_axi_wdata = '0;
    logic [3:0]  s00_axi_wstrb = '0;
    logic        s00_axi_wvalid = 1'b0;
    logic        s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid;
    logic        s00_axi_bready = 1'b1;
    logic [3:0]  s00_axi_araddr = '0;
    logic [2:0]  s00_axi_arprot = '0;
    logic        s00_axi_arvalid = 1'b0;
    logic        s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid;
    logic        s00_axi_rready = 1'b1;
    logic        irq;

    int checkCount = 0;
    int failCount  = 0;

    // Reference state
    logic [31:0] mq[$];
    bit          mEn, mIrqEn, mOvf, mPend, mUnf, mBvalid, mRvalid;
    int          mThresh;
    logic [31:0] mRdata;

    always #5 clk = ~clk;

    emg_irq_notifier #(
        .C_S00_AXI_DATA_WIDTH (32),
        .C_S00_AXI_ADDR_WIDTH (4),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (rst),
        .sample_tdata    (sample_tdata),
        .sample_tvalid   (sample_tvalid),
        .sample_tready   (sample_tready),
        .s00_axi_awaddr  (s00_axi_awaddr),
        .s00_axi_awprot  (s00_axi_awprot),
        .s00_axi_awvalid (s00_axi_awvalid),
        .s00_axi_awready (s00_axi_awready),
        .s00_axi_wdata   (s00_axi_wdata),
        .s00_axi_wstrb   (s00_axi_wstrb),
        .s00_axi_wvalid  (s00_axi_wvalid),
        .s00_axi_wready  (s00_axi_wready),
        .s00_axi_bresp   (s00_axi_bresp),
        .s00_axi_bvalid  (s00_axi_bvalid),
        .s00_axi_bready  (s00_axi_bready),
        .s00_axi_araddr  (s00_axi_araddr),
        .s00_axi_arprot  (s00_axi_arprot),
        .s00_axi_arvalid (s00_axi_arvalid),
        .s00_axi_arready (s00_axi_arready),
        .s00_axi_rdata   (s00_axi_rdata),
        .s00_axi_rresp   (s00_axi_rresp),
        .s00_axi_rvalid  (s00_axi_rvalid),
        .s00_axi_rready  (s00_axi_rready),
        .irq             (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int effThresh(input int t);
        if (t == 0) return 1;
        if (t > DEPTH) return DEPTH;
        return t;
    endfunction

    // Peripheral behaviour in terms of the register map: reads see the state
    // before the edge, a pop makes room before a push, flush drops everything
    // including the sample arriving with it, sticky sets beat W1C clears.
    initial begin : refModel
        int          lvl;
        bit          cond, wrFire, rdFire, flush, c8, c9, c10, ovfSet, unfSet;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mEn = 0; mIrqEn = 0; mOvf = 0; mPend = 0; mUnf = 0;
                mBvalid = 0; mRvalid = 0; mThresh = 8; mRdata = '0;
            end else begin
                lvl    = mq.size();
                cond   = (lvl >= effThresh(mThresh));
                wrFire = s00_axi_awvalid && s00_axi_wvalid && !mBvalid;
                rdFire = s00_axi_arvalid && !mRvalid;
                flush = 0; c8 = 0; c9 = 0; c10 = 0; ovfSet = 0; unfSet = 0;
                if (wrFire && s00_axi_awaddr[3:2] == 2'd0 && s00_axi_wstrb[0])
                    flush = s00_axi_wdata[2];
                if (wrFire && s00_axi_awaddr[3:2] == 2'd2 && s00_axi_wstrb[1]) begin
                    c8 = s00_axi_wdata[8]; c9 = s00_axi_wdata[9]; c10 = s00_axi_wdata[10];
                end
                if (rdFire) begin
                    case (s00_axi_araddr[3:2])
                        2'd0: mRdata = (mIrqEn ? 2 : 0) + (mEn ? 1 : 0);
                        2'd1: mRdata = 32'(mThresh);
                        2'd2: mRdata = 32'(lvl + (mOvf ? 256 : 0) + (mPend ? 512 : 0) + (mUnf ? 1024 : 0));
                        default: begin
                            if (mq.size() == 0) begin
                                mRdata = 32'h0;
                                unfSet = 1;
                            end else begin
                                mRdata = mq.pop_front();
                            end
                        end
                    endcase
                    mRvalid = 1;
                end else if (mRvalid && s00_axi_rready) begin
                    mRvalid = 0;
                end
                if (sample_tvalid && mEn && !flush) begin
                    if (mq.size() < DEPTH) mq.push_back(sample_tdata);
                    else ovfSet = 1;
                end
                if (wrFire) begin
                    if (s00_axi_awaddr[3:2] == 2'd0 && s00_axi_wstrb[0]) begin
                        mEn = s00_axi_wdata[0];
                        mIrqEn = s00_axi_wdata[1];
                    end
                    if (s00_axi_awaddr[3:2] == 2'd1 && s00_axi_wstrb[0])
                        mThresh = int'(s00_axi_wdata[5:0]);
                    mBvalid = 1;
                end else if (mBvalid && s00_axi_bready) begin
                    mBvalid = 0;
                end
                if (flush) mq.delete();
                mOvf  = (mOvf && !c8) || ovfSet;
                mPend = (mPend && !c9) || cond;
                mUnf  = (mUnf && !c10) || unfSet;
            end
        end
    end

    // Registered outputs are compared on every falling edge outside reset.
    initial begin : comparePass
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("irq", 32'(irq), 32'(mPend & mIrqEn));
                checkOutput("sample_tready", 32'(sample_tready), 32'(mEn));
                checkOutput("bvalid", 32'(s00_axi_bvalid), 32'(mBvalid));
                checkOutput("rvalid", 32'(s00_axi_rvalid), 32'(mRvalid));
                checkOutput("rdata", s00_axi_rdata, mRdata);
            end
        end
    end

    // One cycle of sample and/or read-address traffic; returns rdata after it.
    task automatic applyStimulus(input bit push, input logic [31:0] sample, input bit rd,
                                 input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        sample_tvalid   = push;
        sample_tdata    = sample;
        s00_axi_arvalid = rd;
        s00_axi_araddr  = addr;
        @(negedge clk);
        sample_tvalid   = 1'b0;
        s00_axi_arvalid = 1'b0;
        data = s00_axi_rdata;
    endtask

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        s00_axi_awaddr  = addr;
        s00_axi_wdata   = data;
        s00_axi_wstrb   = strb;
        s00_axi_awvalid = 1'b1;
        s00_axi_wvalid  = 1'b1;
        @(negedge clk);
        s00_axi_awvalid = 1'b0;
        s00_axi_wvalid  = 1'b0;
    endtask

    task automatic pushSample(input logic [31:0] d);
        logic [31:0] dummy;
        applyStimulus(1'b1, d, 1'b0, 4'h0, dummy);
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] d);
        applyStimulus(1'b0, 32'h0, 1'b1, addr, d);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset read-back");
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_tready", 32'(sample_tready), 32'h0);
        checkOutput("reset_rdata", s00_axi_rdata, 32'h0);
        readReg(4'h0, d); checkOutput("reset_ctrl", d, 32'h0);
        readReg(4'h4, d); checkOutput("reset_thresh", d, 32'h8);
        readReg(4'h8, d); checkOutput("reset_status", d, 32'h0);

        $display("[TB] threshold interrupt");
        axiWrite(4'h0, 32'h3, 4'hF);
        axiWrite(4'h4, 32'h4, 4'hF);
        pushSample(32'h11); pushSample(32'h22); pushSample(32'h33);
        pushSample(32'h44);
        checkOutput("irq_same_cycle", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("irq_next_cycle", 32'(irq), 32'h1);
        readReg(4'h8, d); checkOutput("status_pending", d, 32'h204);
        for (int i = 0; i < 4; i++) begin
            readReg(4'hC, d);
            checkOutput("drain4", d, 32'h11 * 32'(i + 1));
        end
        axiWrite(4'h8, 32'h200, 4'b0010);
        checkOutput("irq_w1c", 32'(irq), 32'h0);

        $display("[TB] overflow with saturated threshold");
        axiWrite(4'h4, 32'h3F, 4'hF);
        for (int i = 0; i < DEPTH + 1; i++) pushSample(32'h100 + 32'(i));
        readReg(4'h8, d); checkOutput("status_overflow", d, 32'h310);
        checkOutput("irq_saturated", 32'(irq), 32'h1);
        axiWrite(4'h8, 32'h100, 4'b0010);
        readReg(4'h8, d); checkOutput("status_ovf_cleared", d, 32'h210);

        $display("[TB] push and pop while full");
        applyStimulus(1'b1, 32'hAB, 1'b1, 4'hC, d);
        checkOutput("full_simul_read", d, 32'h100);
        readReg(4'h8, d); checkOutput("full_simul_status", d, 32'h210);
        for (int i = 0; i < DEPTH; i++) begin
            readReg(4'hC, d);
            checkOutput("drain_full", d, (i < DEPTH - 1) ? 32'h101 + 32'(i) : 32'hAB);
        end

        $display("[TB] underflow");
        readReg(4'hC, d); checkOutput("empty_read", d, 32'h0);
        readReg(4'h8, d); checkOutput("status_underflow", d, 32'h600);
        applyStimulus(1'b1, 32'h5A, 1'b1, 4'hC, d);
        checkOutput("empty_simul_read", d, 32'h0);
        readReg(4'h8, d); checkOutput("empty_simul_status", d, 32'h601);

        $display("[TB] flush");
        for (int i = 0; i < 4; i++) pushSample(32'h70 + 32'(i));
        readReg(4'h8, d); checkOutput("level5", d, 32'h605);
        axiWrite(4'h0, 32'h5, 4'hF);
        readReg(4'h0, d); checkOutput("ctrl_after_flush", d, 32'h1);
        readReg(4'h8, d); checkOutput("status_after_flush", d, 32'h600);

        $display("[TB] zero threshold and write strobes");
        axiWrite(4'h8, 32'h700, 4'b0010);
        readReg(4'h8, d); checkOutput("status_all_cleared", d, 32'h0);
        axiWrite(4'h4, 32'h0, 4'hF);
        axiWrite(4'h4, 32'h3F, 4'b0000);
        readReg(4'h4, d); checkOutput("thresh_no_strobe", d, 32'h0);
        pushSample(32'h99);
        readReg(4'h8, d); checkOutput("thresh_zero_pending", d, 32'h201);

        $display("[TB] reset during write response");
        s00_axi_bready = 1'b0;
        axiWrite(4'h4, 32'h3, 4'hF);
        checkOutput("bvalid_held", 32'(s00_axi_bvalid), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("bvalid_async_reset", 32'(s00_axi_bvalid), 32'h0);
        checkOutput("tready_async_reset", 32'(sample_tready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        s00_axi_bready = 1'b1;
        readReg(4'h0, d); checkOutput("post_reset_ctrl", d, 32'h0);
        readReg(4'h4, d); checkOutput("post_reset_thresh", d, 32'h8);
        readReg(4'h8, d); checkOutput("post_reset_status", d, 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
